// File: rtl/skut_pkg.sv
// Shared types and timing defaults for the SKUT MBR line receiver.
package skut_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC_LO,
    BITS
  } state_e;

  localparam int HALF_DEF = 126;
  localparam int TOL_DEF  = 16;
  localparam int GAP_DEF  = 2016;
  localparam int RUN_W    = 12;
  localparam int NBITS    = 17;

  // Sync high (and low) length in cycles.
  function automatic int sync_len(input int half);
    return 3 * half;
  endfunction

  // Offset from t0 of the parity bit's second-half sample (4599 at default HALF).
  function automatic int last_sample(input int half);
    return 36 * half + half / 2;
  endfunction

endpackage

// File: rtl/skut_line_sampler.sv
// Two-flop synchronizer for the MBR line plus a saturating run-length counter
// of the synchronized level.
module skut_line_sampler
  import skut_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             din_i,
  input  logic             clr_i,
  output logic             ds_o,
  output logic             lvl_end_o,
  output logic [RUN_W-1:0] len_o
);

  logic             s1_q;
  logic             ds_q;
  logic [RUN_W-1:0] run_q;

  // len_o is the length of the current level including this cycle, so while
  // lvl_end_o is high it is the full length of the level that is ending.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_q  <= 1'b0;
      ds_q  <= 1'b0;
      run_q <= '0;
    end else begin
      s1_q <= din_i;
      ds_q <= s1_q;
      if (ds_q != s1_q) begin
        run_q <= RUN_W'(1);
      end else if (clr_i) begin
        run_q <= '0;
      end else if (run_q != '1) begin
        run_q <= run_q + 1'b1;
      end
    end
  end

  assign ds_o      = ds_q;
  assign lvl_end_o = ds_q ^ s1_q;
  assign len_o     = run_q;

endmodule

// File: rtl/skut_mbr_rx.sv
// SKUT MBR frame-base receiver: hunts the word sync, decodes 16 Manchester-II
// data bits plus odd parity, and tracks frame start and word index.
module skut_mbr_rx
  import skut_pkg::*;
#(
  parameter int HALF = HALF_DEF,
  parameter int TOL  = TOL_DEF,
  parameter int GAP  = GAP_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        din_i,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic [7:0]  word_idx_o,
  output logic        frame_start_o,
  output logic        err_parity_o,
  output logic        err_manch_o,
  output logic        busy_o
);

  localparam logic [RUN_W-1:0] WIN_LO   = RUN_W'(sync_len(HALF) - TOL);
  localparam logic [RUN_W-1:0] WIN_HI   = RUN_W'(sync_len(HALF) + TOL);
  localparam logic [RUN_W-1:0] GAP_MIN  = RUN_W'(GAP);
  localparam logic [RUN_W-1:0] LD_SYNC  = RUN_W'(HALF / 2);
  localparam logic [RUN_W-1:0] LD_FIRST = RUN_W'(sync_len(HALF) - 1);
  localparam logic [RUN_W-1:0] LD_HALF  = RUN_W'(HALF - 1);
  localparam logic [4:0]       LAST_BIT = 5'(NBITS - 1);

  logic             ds;
  logic             lvl_end;
  logic [RUN_W-1:0] run_len;
  logic             in_win;

  state_e           state_q;
  logic [RUN_W-1:0] timer_q;
  logic [RUN_W-1:0] gap_q;
  logic [4:0]       bit_q;
  logic             half_q;
  logic             first_q;
  logic [15:0]      sr_q;
  logic             fs_pend_q;
  logic             clr_q;
  logic [15:0]      data_q;
  logic             valid_q;
  logic [7:0]       idx_q;
  logic             fs_q;
  logic             par_q;
  logic             manch_q;
  logic             busy_q;

  skut_line_sampler u_sampler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .din_i     (din_i),
    .clr_i     (clr_q),
    .ds_o      (ds),
    .lvl_end_o (lvl_end),
    .len_o     (run_len)
  );

  assign in_win = (run_len >= WIN_LO) && (run_len <= WIN_HI);

  // Decisions are taken one cycle ahead of the line change (lvl_end), so the
  // state and busy are already updated in t0 itself.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= HUNT;
      timer_q   <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      half_q    <= 1'b0;
      first_q   <= 1'b0;
      sr_q      <= '0;
      fs_pend_q <= 1'b0;
      clr_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      fs_q      <= 1'b0;
      par_q     <= 1'b0;
      manch_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      manch_q <= 1'b0;
      clr_q   <= 1'b0;
      case (state_q)
        HUNT: begin
          if (lvl_end && !ds) begin
            gap_q <= run_len;
          end else if (lvl_end && ds && in_win) begin
            state_q   <= SYNC_LO;
            busy_q    <= 1'b1;
            timer_q   <= LD_SYNC;
            fs_pend_q <= (gap_q >= GAP_MIN);
          end
        end
        SYNC_LO: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else if (ds) begin
            manch_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= HUNT;
          end else begin
            state_q <= BITS;
            timer_q <= LD_FIRST;
            bit_q   <= '0;
            half_q  <= 1'b0;
          end
        end
        BITS: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else if (!half_q) begin
            first_q <= ds;
            half_q  <= 1'b1;
            timer_q <= LD_HALF;
          end else if (ds == first_q) begin
            manch_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= HUNT;
          end else if (bit_q == LAST_BIT) begin
            valid_q <= 1'b1;
            data_q  <= sr_q;
            par_q   <= ~(^{sr_q, first_q});
            fs_q    <= fs_pend_q;
            if (fs_pend_q) begin
              idx_q <= '0;
            end else if (idx_q != 8'hFF) begin
              idx_q <= idx_q + 8'd1;
            end
            busy_q  <= 1'b0;
            clr_q   <= 1'b1;
            state_q <= HUNT;
          end else begin
            sr_q    <= {sr_q[14:0], first_q};
            bit_q   <= bit_q + 1'b1;
            half_q  <= 1'b0;
            timer_q <= LD_HALF;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign word_idx_o    = idx_q;
  assign frame_start_o = fs_q;
  assign err_parity_o  = par_q;
  assign err_manch_o   = manch_q;
  assign busy_o        = busy_q;

endmodule
